rename_alloc_scheduler: RTL and testbench
=========================================

Name: rename_alloc_scheduler

Overview:
- Controller that sequences the physical-register free list for the rename stage.
- Grants free-list pops to NUM_SLOTS in-order rename slots, limited by free count.
- Buffers released PRNs from commit and pushes them back into the free list at one per cycle.
- Runs a flush-drain sequence so recovery starts from a consistent free list.

Parameters:
- NUM_SLOTS, 2, rename slots per cycle (slot 0 is oldest)
- REL_DEPTH, 4, release buffer entries (power of 2)
- PRN_W, 6, physical register number width (48 pregs)
- FL_CNT_W, 5, width of the free-list occupancy count (0..MAX_FREE_REGS=16)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ren_req_i  in  NUM_SLOTS  per-slot allocation request
- ren_gnt_o  out  NUM_SLOTS  per-slot grant (same cycle)
- ren_stall_o  out  1  some requesting slot not granted
- fl_count_i  in  FL_CNT_W  free PRNs currently available
- fl_full_i  in  1  free list cannot accept a push
- fl_pop_cnt_o  out  $clog2(NUM_SLOTS+1)  PRNs to pop this cycle
- fl_push_o  out  1  push fl_push_prn_o this cycle
- fl_push_prn_o  out  PRN_W  PRN returned to free list
- rel_valid_i  in  1  commit releases a PRN
- rel_prn_i  in  PRN_W  released PRN
- rel_ready_o  out  1  release buffer accepts
- flush_i  in  1  pipeline flush request (pulse)
- flush_done_o  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset (async, rst_n=0):
  - State RUN; release buffer empty with pointers at 0.
  - ren_gnt_o=0, fl_pop_cnt_o=0, fl_push_o=0, fl_push_prn_o=0, flush_done_o=0, ren_stall_o=0.
  - rel_ready_o=1 from the first cycle after reset.
  - Reset mid-drain discards buffered PRNs; the free list reinitialises itself.
- Grant is combinational, prefix-ordered:
  - ren_gnt_o[i]=1 iff state==RUN, !flush_i, ren_req_i[0..i] all 1, and i < fl_count_i.
  - A younger slot is never granted when an older slot is not.
  - A gap (ren_req_i=2'b10) grants nothing and raises stall.
- fl_pop_cnt_o = popcount(ren_gnt_o).
- ren_stall_o = |(ren_req_i & ~ren_gnt_o).
- Release buffer:
  - FIFO, rel_ready_o = !full && state==RUN.
  - A PRN enqueued at cycle N is pushable no earlier than N+1; there is no bypass.
  - Simultaneous enqueue and dequeue are legal.
  - Full: rel_ready_o=0 and no pass-through.
  - Pointers wrap modulo REL_DEPTH; a separate count (0..REL_DEPTH) disambiguates full from empty.
- Push: fl_push_o = !empty && !fl_full_i, with fl_push_prn_o = buffer head. The buffer dequeues in the same cycle.
- Pop and push in the same cycle are both issued; the free list handles the ordering.
- FSM, states RUN and DRAIN:
  - RUN, flush_i=1 → DRAIN. Grants are 0 in the flush cycle.
  - DRAIN: grants 0, rel_ready_o=0, and the buffer keeps pushing.
  - DRAIN with buffer empty: flush_done_o=1 that cycle, next state RUN. DRAIN lasts at least one cycle.
  - flush_i in DRAIN is ignored.
  - fl_full_i held high in DRAIN stalls the drain indefinitely; this is legal.

Optional Feature:
- Macro: ALLOC_STATS_EN.
- Defined:
  - Adds outputs stall_cycles_o[15:0] and alloc_total_o[15:0], both reset to 0.
  - stall_cycles_o increments on cycles with ren_stall_o=1.
  - alloc_total_o adds fl_pop_cnt_o every cycle.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- cpu_design_params package:
  - Existing: prn_t, NUM_A_REGS, MAX_FREE_REGS.
  - Add alloc_state_e {ALLOC_RUN, ALLOC_DRAIN} and REL_DEPTH default.
- Sub-module prn_release_fifo (parameterised depth/width, push/pop/full/empty/count) holds the release buffer.
- Grant logic and FSM stay in the top.

Test Plan:
- Reset then fl_count_i=16, ren_req_i=2'b11 → ren_gnt_o=2'b11, fl_pop_cnt_o=2, ren_stall_o=0, rel_ready_o=1.
- fl_count_i=1, ren_req_i=2'b11 → gnt=2'b01, pop_cnt=1, stall=1. fl_count_i=0 → gnt=0. ren_req_i=2'b10 → gnt=0, stall=1.
- rel_valid_i with PRN 33 at cycle N, fl_full_i=0 → fl_push_o=1, fl_push_prn_o=33 at N+1, not at N.
- fl_full_i=1 and 4 releases (PRNs 40..43) → rel_ready_o=0 after the 4th. Deassert fl_full_i → pushes 40,41,42,43 on 4 consecutive cycles, then rel_ready_o=1.
- Buffer holds 2 PRNs, flush_i pulse with ren_req_i=2'b11 → gnt=0 in the flush cycle and during DRAIN, rel_ready_o=0, 2 pushes, flush_done_o single pulse, then RUN and grants resume.
- rst_n low mid-DRAIN with 3 buffered → all outputs at reset values, state RUN, no push after release. With ALLOC_STATS_EN, counters read 0 and saturate after a forced 65536 stall cycles.

Source files
------------

// File: rtl/cpu_design_params.sv
// rtl/cpu_design_params.sv - shared CPU design parameters and rename-allocator types
package cpu_design_params;

  localparam int NUM_A_REGS    = 32;
  localparam int MAX_FREE_REGS = 16;
  localparam int PRN_W         = 6;
  localparam int REL_DEPTH     = 4;

  typedef logic [PRN_W-1:0] prn_t;

  typedef enum logic {
    ALLOC_RUN   = 1'b0,
    ALLOC_DRAIN = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/prn_release_fifo.sv
// rtl/prn_release_fifo.sv - release buffer FIFO for PRNs returned by commit
module prn_release_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two; the count tells full from empty.
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/rename_alloc_scheduler.sv
// rtl/rename_alloc_scheduler.sv - free-list pop/push sequencer for the rename stage
// Optional ALLOC_STATS_EN adds saturating stall/allocation counters.
module rename_alloc_scheduler #(
  parameter int NUM_SLOTS = 2,
  parameter int REL_DEPTH = cpu_design_params::REL_DEPTH,
  parameter int PRN_W     = cpu_design_params::PRN_W,
  parameter int FL_CNT_W  = 5,
  localparam int PCW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] ren_req_i,
  output logic [NUM_SLOTS-1:0] ren_gnt_o,
  output logic                 ren_stall_o,
  input  logic [FL_CNT_W-1:0]  fl_count_i,
  input  logic                 fl_full_i,
  output logic [PCW-1:0]       fl_pop_cnt_o,
  output logic                 fl_push_o,
  output logic [PRN_W-1:0]     fl_push_prn_o,
  input  logic                 rel_valid_i,
  input  logic [PRN_W-1:0]     rel_prn_i,
  output logic                 rel_ready_o,
  input  logic                 flush_i,
  output logic                 flush_done_o
`ifdef ALLOC_STATS_EN
  ,
  output logic [15:0]          stall_cycles_o,
  output logic [15:0]          alloc_total_o
`endif
);

  import cpu_design_params::*;

  localparam int RCW = $clog2(REL_DEPTH + 1);

  alloc_state_e state_q, state_d;
  logic         rel_full, rel_empty;
  logic [RCW-1:0] rel_count;
  logic         prefix_ok;

  prn_release_fifo #(
    .DEPTH (REL_DEPTH),
    .WIDTH (PRN_W)
  ) u_rel_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rel_valid_i && rel_ready_o),
    .push_data_i (rel_prn_i),
    .pop_i       (fl_push_o),
    .pop_data_o  (fl_push_prn_o),
    .full_o      (rel_full),
    .empty_o     (rel_empty),
    .count_o     (rel_count)
  );

  // In-order grant: a slot wins only if every older slot also requests and a PRN remains.
  always_comb begin
    ren_gnt_o    = '0;
    fl_pop_cnt_o = '0;
    prefix_ok    = (state_q == ALLOC_RUN) && !flush_i;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      prefix_ok    = prefix_ok && ren_req_i[i] && (i < int'(fl_count_i));
      ren_gnt_o[i] = prefix_ok;
      fl_pop_cnt_o = fl_pop_cnt_o + PCW'(prefix_ok);
    end
  end

  assign ren_stall_o = |(ren_req_i & ~ren_gnt_o);
  assign fl_push_o   = !rel_empty && !fl_full_i;
  assign rel_ready_o = !rel_full && (state_q == ALLOC_RUN);

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    case (state_q)
      ALLOC_RUN: begin
        if (flush_i) state_d = ALLOC_DRAIN;
      end
      ALLOC_DRAIN: begin
        if (rel_count == '0) begin
          flush_done_o = 1'b1;
          state_d      = ALLOC_RUN;
        end
      end
      default: state_d = ALLOC_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ALLOC_RUN;
    else        state_q <= state_d;
  end

`ifdef ALLOC_STATS_EN
  logic [15:0] stall_q, stall_d, alloc_q, alloc_d;
  logic [16:0] alloc_sum;

  assign alloc_sum      = {1'b0, alloc_q} + 17'(fl_pop_cnt_o);
  assign alloc_d        = alloc_sum[16] ? 16'hFFFF : alloc_sum[15:0];
  assign stall_d        = (ren_stall_o && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  assign stall_cycles_o = stall_q;
  assign alloc_total_o  = alloc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      alloc_q <= '0;
    end else begin
      stall_q <= stall_d;
      alloc_q <= alloc_d;
    end
  end
`endif

endmodule

// File: tb/tb_rename_alloc_scheduler.sv
// tb/tb_rename_alloc_scheduler.sv - randomized self-checking bench with a queue-based reference model
module tb_rename_alloc_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ren_req;
  logic [1:0] ren_gnt;
  logic       ren_stall;
  logic [4:0] fl_count;
  logic       fl_full;
  logic [1:0] fl_pop_cnt;
  logic       fl_push;
  logic [5:0] fl_push_prn;
  logic       rel_valid;
  logic [5:0] rel_prn;
  logic       rel_ready;
  logic       flush;
  logic       flush_done;
`ifdef ALLOC_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] alloc_total;
`endif

  int checks = 0;
  int errors = 0;

  int q[$];
  bit m_drain;
  int m_stall, m_alloc;

  logic [1:0] e_gnt;
  logic [1:0] e_pop;
  logic       e_stall, e_push, e_ready, e_done;
  logic [5:0] e_prn;
  logic [13:0] exp_v, obs_v;

  always #5 clk = ~clk;

  rename_alloc_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ren_req_i     (ren_req),
    .ren_gnt_o     (ren_gnt),
    .ren_stall_o   (ren_stall),
    .fl_count_i    (fl_count),
    .fl_full_i     (fl_full),
    .fl_pop_cnt_o  (fl_pop_cnt),
    .fl_push_o     (fl_push),
    .fl_push_prn_o (fl_push_prn),
    .rel_valid_i   (rel_valid),
    .rel_prn_i     (rel_prn),
    .rel_ready_o   (rel_ready),
    .flush_i       (flush),
    .flush_done_o  (flush_done)
`ifdef ALLOC_STATS_EN
    ,
    .stall_cycles_o(stall_cycles),
    .alloc_total_o (alloc_total)
`endif
  );

  task automatic model_reset();
    q.delete();
    m_drain = 0;
    m_stall = 0;
    m_alloc = 0;
  endtask

  // Drives one cycle, predicts outputs from the model, samples the DUT, then advances the model.
  task automatic step(input logic [1:0] req, input int cnt, input logic full,
                      input logic rv, input logic [5:0] rp, input logic fl);
    int lead, g;
    @(negedge clk);
    ren_req = req; fl_count = 5'(cnt); fl_full = full;
    rel_valid = rv; rel_prn = rp; flush = fl;
    #1;
    lead = 0;
    while (lead < 2 && req[lead]) lead++;
    g = (!m_drain && !fl) ? ((lead < cnt) ? lead : cnt) : 0;
    e_gnt   = 2'((1 << g) - 1);
    e_pop   = 2'(g);
    e_stall = (req & ~e_gnt) != 2'b00;
    e_push  = (q.size() > 0) && !full;
    e_prn   = e_push ? 6'(q[0]) : 6'd0;
    e_ready = (q.size() < 4) && !m_drain;
    e_done  = m_drain && (q.size() == 0);
    exp_v = {e_gnt, e_pop, e_stall, e_push, e_prn, e_ready, e_done};
    obs_v = {ren_gnt, fl_pop_cnt, ren_stall, fl_push, (e_push ? fl_push_prn : 6'd0), rel_ready, flush_done};
    @(posedge clk);
    if (e_push) void'(q.pop_front());
    if (rv && e_ready) q.push_back(int'(rp));
    if (!m_drain && fl) m_drain = 1;
    else if (m_drain && e_done) m_drain = 0;
    m_stall = (m_stall + int'(e_stall) > 65535) ? 65535 : m_stall + int'(e_stall);
    m_alloc = (m_alloc + g > 65535) ? 65535 : m_alloc + g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ren_req = 2'b00; fl_count = 5'd0; fl_full = 1'b0;
    rel_valid = 1'b0; rel_prn = 6'd0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ren_gnt, fl_pop_cnt, ren_stall, fl_push, fl_push_prn, flush_done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b pop=%0d stall=%b push=%b prn=%0d done=%b want all 0",
               ren_gnt, fl_pop_cnt, ren_stall, fl_push, fl_push_prn, flush_done);
    end
    rst_n = 1'b1;
    step(2'b11, 16, 1'b0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (obs_v !== exp_v || ren_gnt !== 2'b11 || fl_pop_cnt !== 2'd2 || rel_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got %b want %b", obs_v, exp_v);
    end
`ifdef ALLOC_STATS_EN
    checks++;
    if (stall_cycles !== 16'd0 || alloc_total !== 16'(m_alloc)) begin
      errors++;
      $display("FAIL stats_after_reset got stall=%0d alloc=%0d want 0 %0d", stall_cycles, alloc_total, m_alloc);
    end
`endif
  endtask

  task automatic test_grant();
    logic [1:0] reqs [4] = '{2'b11, 2'b11, 2'b10, 2'b01};
    int cnts [4] = '{1, 0, 16, 5};
    logic [1:0] gnts [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      step(reqs[i], cnts[i], 1'b0, 1'b0, 6'd0, 1'b0);
      checks++;
      if (obs_v !== exp_v || ren_gnt !== gnts[i]) begin
        errors++;
        $display("FAIL grant_%0d got gnt=%b obs=%b want gnt=%b exp=%b", i, ren_gnt, obs_v, gnts[i], exp_v);
      end
    end
  endtask

  task automatic test_release_latency();
    step(2'b00, 16, 1'b0, 1'b1, 6'd33, 1'b0);
    checks++;
    if (obs_v !== exp_v || fl_push !== 1'b0) begin
      errors++;
      $display("FAIL rel_no_bypass got push=%b obs=%b want push=0 exp=%b", fl_push, obs_v, exp_v);
    end
    step(2'b00, 16, 1'b0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (obs_v !== exp_v || fl_push !== 1'b1 || fl_push_prn !== 6'd33) begin
      errors++;
      $display("FAIL rel_push_next got push=%b prn=%0d want push=1 prn=33", fl_push, fl_push_prn);
    end
  endtask

  task automatic test_full_buffer();
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 16, 1'b1, 1'b1, 6'(40 + i), 1'b0);
      checks++;
      if (obs_v !== exp_v || rel_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_%0d got obs=%b want %b", i, obs_v, exp_v);
      end
    end
    step(2'b00, 16, 1'b1, 1'b1, 6'd50, 1'b0);
    checks++;
    if (obs_v !== exp_v || rel_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got ready=%b want 0", rel_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 16, 1'b0, 1'b0, 6'd0, 1'b0);
      checks++;
      if (obs_v !== exp_v || fl_push !== 1'b1 || fl_push_prn !== 6'(40 + i)) begin
        errors++;
        $display("FAIL drain_order_%0d got push=%b prn=%0d want push=1 prn=%0d", i, fl_push, fl_push_prn, 40 + i);
      end
    end
    step(2'b00, 16, 1'b0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (obs_v !== exp_v || rel_ready !== 1'b1 || fl_push !== 1'b0) begin
      errors++;
      $display("FAIL after_drain got ready=%b push=%b want 1 0", rel_ready, fl_push);
    end
  endtask

  task automatic test_flush();
    int pushes, dones, n;
    step(2'b00, 16, 1'b1, 1'b1, 6'd7, 1'b0);
    step(2'b00, 16, 1'b1, 1'b1, 6'd8, 1'b0);
    pushes = 0; dones = 0; n = 0;
    step(2'b11, 16, 1'b0, 1'b0, 6'd0, 1'b1);
    checks++;
    if (obs_v !== exp_v || ren_gnt !== 2'b00) begin
      errors++;
      $display("FAIL flush_cycle_gnt got gnt=%b obs=%b want gnt=00 exp=%b", ren_gnt, obs_v, exp_v);
    end
    pushes += int'(fl_push);
    while (dones == 0 && n < 10) begin
      step(2'b11, 16, 1'b0, 1'b0, 6'd0, 1'b0);
      n++;
      pushes += int'(fl_push);
      dones  += int'(flush_done);
      checks++;
      if (obs_v !== exp_v || ren_gnt !== 2'b00 || rel_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_cycle_%0d got obs=%b want %b", n, obs_v, exp_v);
      end
    end
    checks++;
    if (dones != 1 || pushes != 2) begin
      errors++;
      $display("FAIL flush_summary got done=%0d pushes=%0d want 1 2", dones, pushes);
    end
    step(2'b11, 16, 1'b0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (obs_v !== exp_v || ren_gnt !== 2'b11 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL resume_run got gnt=%b done=%b want 11 0", ren_gnt, flush_done);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) step(2'b00, 16, 1'b1, 1'b1, 6'(20 + i), 1'b0);
    step(2'b01, 16, 1'b1, 1'b0, 6'd0, 1'b1);
    step(2'b01, 16, 1'b1, 1'b0, 6'd0, 1'b0);
    checks++;
    if (obs_v !== exp_v || rel_ready !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL in_drain got obs=%b want %b", obs_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b0;
    ren_req = 2'b00; fl_full = 1'b0; rel_valid = 1'b0; flush = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ren_gnt, fl_pop_cnt, ren_stall, fl_push, fl_push_prn, flush_done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_drain got gnt=%b push=%b prn=%0d done=%b want 0", ren_gnt, fl_push, fl_push_prn, flush_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 16, 1'b0, 1'b0, 6'd0, 1'b0);
      checks++;
      if (obs_v !== exp_v || fl_push !== 1'b0 || rel_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_%0d got push=%b ready=%b want 0 1", i, fl_push, rel_ready);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom), int'($urandom_range(0, 16)), ($urandom_range(0, 3) == 0),
           1'($urandom), 6'($urandom), ($urandom_range(0, 19) == 0));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random_%0d got %b want %b", i, obs_v, exp_v);
      end
    end
`ifdef ALLOC_STATS_EN
    checks++;
    if (stall_cycles !== 16'(m_stall) || alloc_total !== 16'(m_alloc)) begin
      errors++;
      $display("FAIL stats_random got stall=%0d alloc=%0d want %0d %0d", stall_cycles, alloc_total, m_stall, m_alloc);
    end
`endif
  endtask

`ifdef ALLOC_STATS_EN
  task automatic test_stats_saturate();
    @(negedge clk);
    ren_req = 2'b01; fl_count = 5'd0; fl_full = 1'b0; rel_valid = 1'b0; flush = 1'b0;
    repeat (65536) @(posedge clk);
    m_stall = 65535;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'hFFFF || alloc_total !== 16'(m_alloc)) begin
      errors++;
      $display("FAIL stats_saturate got stall=%h alloc=%0d want ffff %0d", stall_cycles, alloc_total, m_alloc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_grant();
    test_release_latency();
    test_full_buffer();
    test_flush();
    test_reset_mid_drain();
    test_random();
`ifdef ALLOC_STATS_EN
    test_stats_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
